// File: rtl/sdcmd_responder_if.sv
// rtl/sdcmd_responder_if.sv - host-side command/response bundle of the SD CMD responder
// The responder drives received-command fields and status; the host drives the response request.
interface sdcmd_responder_if;
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_crcerr;
  logic        cmd_frameerr;
  logic        resp_start;
  logic [5:0]  resp_idx;
  logic [31:0] resp_arg;
  logic        resp_nocrc;
  logic        resp_ready;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_idx, cmd_arg, cmd_crcerr, cmd_frameerr, resp_ready, busy,
    output resp_start, resp_idx, resp_arg, resp_nocrc
  );

  modport slave (
    output cmd_valid, cmd_idx, cmd_arg, cmd_crcerr, cmd_frameerr, resp_ready, busy,
    input  resp_start, resp_idx, resp_arg, resp_nocrc
  );
endinterface

// File: rtl/sdcmd_responder.sv
// rtl/sdcmd_responder.sv - SD card-side CMD line receiver and response transmitter
// Works entirely in the clk domain: sdclk and the CMD line are synchronised, the CMD
// line is sampled on sdclk rise strobes and driven on sdclk fall strobes.
module sdcmd_responder #(
  parameter int NCR = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sdclk,
  input  logic sdcmd_in,
  output logic sdcmd_out,
  output logic sdcmd_oe,
  sdcmd_responder_if.slave host
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_WAIT_RESP, S_GAP, S_TX, S_REL
  } state_t;

  localparam logic [5:0] NCR_LAST = 6'(NCR - 1);

  // One CRC7 step, polynomial x^7 + x^3 + 1, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  // CRC7 over a 40-bit frame header, initial value 0.
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) crc = crc7_step(crc, d[i]);
    return crc;
  endfunction

  state_t      state_q, state_d;
  logic        sdclk_s1_q, sdclk_s1_d, sdclk_s2_q, sdclk_s2_d, sdclk_s3_q, sdclk_s3_d;
  logic        cmd_s1_q, cmd_s1_d, cmd_s2_q, cmd_s2_d;
  logic [45:0] rx_shift_q, rx_shift_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [5:0]  gap_cnt_q, gap_cnt_d;
  logic [47:0] tx_shift_q, tx_shift_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic        out_q, out_d, oe_q, oe_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        cmd_crcerr_q, cmd_crcerr_d;
  logic        cmd_frameerr_q, cmd_frameerr_d;

  logic        rise, fall, start_seen;
  logic [47:0] frame;
  logic [39:0] resp_hdr;

  assign rise       = sdclk_s2_q & ~sdclk_s3_q;
  assign fall       = ~sdclk_s2_q & sdclk_s3_q;
  assign start_seen = rise & ~cmd_s2_q;
  // Complete frame as it stands once the bit being sampled now is shifted in.
  assign frame      = {1'b0, rx_shift_q, cmd_s2_q};
  assign resp_hdr   = {2'b00, host.resp_idx, host.resp_arg};

  // Register all state; reset releases the line on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sdclk_s1_q     <= 1'b1;
      sdclk_s2_q     <= 1'b1;
      sdclk_s3_q     <= 1'b1;
      cmd_s1_q       <= 1'b1;
      cmd_s2_q       <= 1'b1;
      rx_shift_q     <= '0;
      rx_cnt_q       <= '0;
      gap_cnt_q      <= '0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      out_q          <= 1'b1;
      oe_q           <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_idx_q      <= '0;
      cmd_arg_q      <= '0;
      cmd_crcerr_q   <= 1'b0;
      cmd_frameerr_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sdclk_s1_q     <= sdclk_s1_d;
      sdclk_s2_q     <= sdclk_s2_d;
      sdclk_s3_q     <= sdclk_s3_d;
      cmd_s1_q       <= cmd_s1_d;
      cmd_s2_q       <= cmd_s2_d;
      rx_shift_q     <= rx_shift_d;
      rx_cnt_q       <= rx_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      out_q          <= out_d;
      oe_q           <= oe_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_idx_q      <= cmd_idx_d;
      cmd_arg_q      <= cmd_arg_d;
      cmd_crcerr_q   <= cmd_crcerr_d;
      cmd_frameerr_q <= cmd_frameerr_d;
    end
  end

  // Next-state decision; resp_start takes priority over a new start bit in WAIT_RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start_seen) state_d = S_RX;
      S_RX:        if (rise && rx_cnt_q == 6'd1) state_d = S_CHECK;
      S_CHECK:     state_d = (cmd_crcerr_q || cmd_frameerr_q) ? S_IDLE : S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (host.resp_start)  state_d = S_GAP;
        else if (start_seen)  state_d = S_RX;
      end
      S_GAP:       if (fall && gap_cnt_q == NCR_LAST) state_d = S_TX;
      S_TX:        if (fall && tx_cnt_q == 6'd1) state_d = S_REL;
      S_REL:       if (fall) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and line drive: shift in on rise, shift out on fall, latch fields at the end bit.
  always_comb begin
    sdclk_s1_d     = sdclk;
    sdclk_s2_d     = sdclk_s1_q;
    sdclk_s3_d     = sdclk_s2_q;
    cmd_s1_d       = sdcmd_in;
    cmd_s2_d       = cmd_s1_q;
    rx_shift_d     = rx_shift_q;
    rx_cnt_d       = rx_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    out_d          = out_q;
    oe_d           = oe_q;
    cmd_valid_d    = 1'b0;
    cmd_idx_d      = cmd_idx_q;
    cmd_arg_d      = cmd_arg_q;
    cmd_crcerr_d   = cmd_crcerr_q;
    cmd_frameerr_d = cmd_frameerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_seen) begin
          rx_shift_d = '0;
          rx_cnt_d   = 6'd47;
        end
      end
      S_RX: begin
        if (rise) begin
          rx_shift_d = {rx_shift_q[44:0], cmd_s2_q};
          if (rx_cnt_q != 6'd0) rx_cnt_d = rx_cnt_q - 6'd1;
          if (rx_cnt_q == 6'd1) begin
            cmd_valid_d    = 1'b1;
            cmd_idx_d      = frame[45:40];
            cmd_arg_d      = frame[39:8];
            cmd_crcerr_d   = (frame[7:1] != crc7_40(frame[47:8]));
            cmd_frameerr_d = ~frame[46] | ~frame[0];
          end
        end
      end
      S_WAIT_RESP: begin
        if (host.resp_start) begin
          tx_shift_d = {resp_hdr, host.resp_nocrc ? 7'h7F : crc7_40(resp_hdr), 1'b1};
          gap_cnt_d  = '0;
        end else if (start_seen) begin
          rx_shift_d = '0;
          rx_cnt_d   = 6'd47;
        end
      end
      S_GAP: begin
        if (fall) begin
          if (gap_cnt_q == NCR_LAST) begin
            oe_d      = 1'b1;
            out_d     = tx_shift_q[47];
            tx_cnt_d  = 6'd47;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 6'd1;
          end
        end
      end
      S_TX: begin
        if (fall && tx_cnt_q != 6'd0) begin
          out_d    = tx_shift_q[tx_cnt_q - 6'd1];
          tx_cnt_d = tx_cnt_q - 6'd1;
        end
      end
      S_REL: begin
        if (fall) begin
          oe_d  = 1'b0;
          out_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sdcmd_out         = out_q;
  assign sdcmd_oe          = oe_q;
  assign host.cmd_valid    = cmd_valid_q;
  assign host.cmd_idx      = cmd_idx_q;
  assign host.cmd_arg      = cmd_arg_q;
  assign host.cmd_crcerr   = cmd_crcerr_q;
  assign host.cmd_frameerr = cmd_frameerr_q;
  assign host.resp_ready   = (state_q == S_WAIT_RESP);
  assign host.busy         = (state_q == S_GAP) || (state_q == S_TX);

endmodule
